stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
//
// PURPOSE
// - Parametrised N_CH:1 mux for W-bit valid/ready streams; successor to the fixed 4:1 combinational muxes.
// - Two modes: explicit select (sel port) or round-robin arbitration.
// - Packet-aware: the granted channel is locked until its in_last beat is transferred.
// - Output is registered (one stage), so the block can sit between any two stream stages in the datapath.
//
// PARAMETERS
// - N_CH   4   number of input channels, >= 2
// - W      8   data width per channel, >= 1
// - SEL_W  $clog2(N_CH)   derived (localparam), index width
//
// PORTS
// - clk        in   1            rising-edge clock; single clock domain
// - rst        in   1            synchronous, active-high reset
// - mode       in   1            0 = explicit select, 1 = round-robin
// - sel        in   SEL_W        channel index used when mode=0
// - in_valid   in   N_CH         per-channel beat valid
// - in_last    in   N_CH         per-channel end-of-packet flag, qualified by in_valid
// - in_data    in   N_CH*W       channel k occupies bits [k*W +: W]
// - in_ready   out  N_CH         per-channel accept; at most one bit high
// - out_valid  out  1            registered output valid
// - out_last   out  1            registered end-of-packet
// - out_data   out  W            registered data
// - out_ch     out  SEL_W        index of the channel that produced out_data
// - out_ready  in   1            downstream accept
//
// BEHAVIOUR
// - Reset (rst=1 at posedge) clears:
//   - out_valid=0, out_last=0, out_data=0, out_ch=0
//   - state=IDLE, rr_ptr=0, grant=0
//   - in_ready=0 combinationally while rst=1
// - Slot free: slot_free = !out_valid || out_ready. A beat on channel g transfers when in_valid[g] && in_ready[g].
// - in_ready[g] = slot_free && (g == cur_grant) && grant_ok. All other bits are 0.
// - Latency: a beat accepted at edge n appears on out_* after edge n; throughput is 1 beat/cycle.
// - out_* hold their values while out_valid && !out_ready.
// - FSM states IDLE and LOCKED:
//   - IDLE, mode=0: cur_grant = sel; grant_ok = (sel < N_CH) && in_valid[sel].
//   - IDLE, mode=1: cur_grant = first k with in_valid[k] searching rr_ptr, rr_ptr+1, ... mod N_CH; grant_ok = |in_valid.
//   - IDLE: on transfer with in_last=0 -> LOCKED and grant <= cur_grant. On transfer with in_last=1 -> stay IDLE (single-beat packet).
//   - LOCKED: cur_grant = grant; grant_ok = 1. mode, sel and other channels are ignored.
//   - LOCKED: on transfer with in_last=1 -> IDLE.
//   - LOCKED: a gap with in_valid[grant]=0 keeps LOCKED and emits no bubble beat.
// - rr_ptr is updated only on a last-beat transfer: rr_ptr <= (cur_grant == N_CH-1) ? 0 : cur_grant+1. This holds in both modes.
// - sel >= N_CH with N_CH not a power of 2: no grant and all in_ready=0. This is not an error.
// - Reset mid-packet: the partial packet is dropped, the FSM returns to IDLE, and out_valid=0 next cycle. The upstream must restart that packet.
// - out_ready low while LOCKED: back-pressure propagates only to in_ready[grant].
// - mode or sel change mid-packet takes effect only at the next IDLE arbitration.
//
// STRUCTURE
// - Package stream_mux_pkg holds:
//   - state enum {ST_IDLE, ST_LOCKED}
//   - function idx_w(n) returning max(1, $clog2(n))
// - Sub-module rr_arbiter #(N_CH) is combinational: inputs req[N_CH] and ptr; outputs gnt_idx and any_gnt.
// - The top holds the FSM, the grant/rr_ptr registers, the output register and the in_ready decode.
//
// TESTING (N_CH=4, W=8 unless noted)
// - Reset: hold rst 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=00; first grant after release goes to ch0 in mode 1.
// - Explicit mode: mode=0, sel=2, ch2 sends 3 beats 0xA0/A1/A2 (last on A2), out_ready=1 -> out_data A0,A1,A2 on consecutive cycles with out_ch=2, out_last only on A2.
// - Round-robin: mode=1, all channels stream single-beat packets continuously -> out_ch sequence 0,1,2,3,0,... with no idle cycles.
// - Lock: mode=1, ch1 sends a 4-beat packet, ch3 valid throughout -> all ch1 beats go out before any ch3 beat; in_ready[3]=0 until ch1's last beat transfers.
// - Back-pressure: out_ready=0 for 5 cycles mid-packet -> out_data/out_ch are stable, exactly one beat is held, in_ready[grant]=0, and no beat is lost or duplicated (scoreboard).
// - Reset mid-packet, then N_CH=3 with sel=3: after reset the FSM is in IDLE and round-robin restarts at ch0; with N_CH=3, mode=0, sel=3 -> in_ready=000 permanently.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared types and helpers for the round-robin / explicit-select stream mux.
package stream_mux_pkg;

  // Arbitration state: free to pick a channel, or locked to one until its last beat
  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  // Index width for n items, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N_CH.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = idx_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any_gnt
);

  int   idx;
  logic found;

  // Walk ptr, ptr+1, ... (mod N_CH) and take the first active request
  always_comb begin
    gnt_idx = '0;
    any_gnt = |req;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      for (int k = 0; k < N_CH; k++) begin
        if (!found && (k == idx) && req[k]) begin
          found   = 1'b1;
          gnt_idx = SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N_CH:1 packet-aware stream mux with explicit-select or round-robin arbitration
// and a single registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int W     = 8,
  localparam int SEL_W = idx_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH-1:0]   in_last,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  input  logic              out_ready
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [W-1:0]       out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;

  logic [SEL_W-1:0]   arb_idx;
  logic               arb_any;
  logic [SEL_W-1:0]   cur_grant;
  logic               grant_ok;
  logic               sel_valid;
  logic               slot_free;
  logic               xfer;
  logic               beat_last;
  logic [W-1:0]       beat_data;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  assign slot_free = !out_valid_q || out_ready;

  // Pick the candidate channel: locked owner, round-robin winner, or sel (out-of-range sel never matches)
  always_comb begin
    cur_grant = grant_q;
    grant_ok  = 1'b1;
    sel_valid = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == sel) begin
        sel_valid = in_valid[k];
      end
    end
    if (state_q == ST_IDLE) begin
      if (mode) begin
        cur_grant = arb_idx;
        grant_ok  = arb_any;
      end else begin
        cur_grant = sel;
        grant_ok  = sel_valid;
      end
    end
  end

  // Decode in_ready to the single granted channel and steer its beat toward the output register
  always_comb begin
    in_ready  = '0;
    beat_last = 1'b0;
    beat_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == cur_grant) begin
        in_ready[k] = slot_free && grant_ok && !rst;
        beat_last   = in_last[k];
        beat_data   = in_data[k*W +: W];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Packet lock FSM, grant capture and round-robin pointer advance on last beats
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      if (beat_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (cur_grant == SEL_W'(N_CH - 1)) ? '0 : cur_grant + SEL_W'(1);
      end else begin
        state_d = ST_LOCKED;
        grant_d = cur_grant;
      end
    end
  end

  // Output stage: load on transfer, drop valid once consumed, otherwise hold
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_last_d  = beat_last;
      out_data_d  = beat_data;
      out_ch_d    = cur_grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: directed packets in, expected beats queued,
// a monitor pops and compares every beat the DUT hands downstream.
module tb_stream_mux_rr;

  localparam int NCH = 4;
  localparam int DW  = 8;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic              clk;
  logic              rst;
  logic              mode;
  logic [1:0]        sel;
  logic [NCH-1:0]    inValid;
  logic [NCH-1:0]    inLast;
  logic [NCH*DW-1:0] inData;
  logic [NCH-1:0]    inReady;
  logic              outValid;
  logic              outLast;
  logic [DW-1:0]     outData;
  logic [1:0]        outCh;
  logic              outReady;

  logic              mode3;
  logic [1:0]        sel3;
  logic [2:0]        in3Valid;
  logic [2:0]        in3Last;
  logic [3*DW-1:0]   in3Data;
  logic [2:0]        in3Ready;
  logic              out3Valid;
  logic              out3Last;
  logic [DW-1:0]     out3Data;
  logic [1:0]        out3Ch;
  logic              out3Ready;

  beat_t             srcQ[NCH][$];
  beat_t             expQ[$];
  beat_t             monGot;
  beat_t             monExp;
  logic [NCH-1:0]    fireMask;

  int compared   = 0;
  int mismatched = 0;
  int idleCount;

  stream_mux_rr #(.N_CH(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (inValid),
    .in_last   (inLast),
    .in_data   (inData),
    .in_ready  (inReady),
    .out_valid (outValid),
    .out_last  (outLast),
    .out_data  (outData),
    .out_ch    (outCh),
    .out_ready (outReady)
  );

  stream_mux_rr #(.N_CH(3), .W(8)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .sel       (sel3),
    .in_valid  (in3Valid),
    .in_last   (in3Last),
    .in_data   (in3Data),
    .in_ready  (in3Ready),
    .out_valid (out3Valid),
    .out_last  (out3Last),
    .out_data  (out3Data),
    .out_ch    (out3Ch),
    .out_ready (out3Ready)
  );

  // Free-running clock, rising edge at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Queue one beat on a source channel
  task automatic applyStimulus(input logic [1:0] ch, input logic [DW-1:0] d, input logic l);
    srcQ[ch].push_back('{ch: ch, data: d, last: l});
  endtask

  // Queue one beat the DUT must produce, in output order
  task automatic expectBeat(input logic [1:0] ch, input logic [DW-1:0] d, input logic l);
    expQ.push_back('{ch: ch, data: d, last: l});
  endtask

  // Present the head of every source queue on the input bus
  task automatic driveHeads();
    for (int k = 0; k < NCH; k++) begin
      if (srcQ[k].size() > 0) begin
        inValid[k]            = 1'b1;
        inLast[k]             = srcQ[k][0].last;
        inData[k*DW +: DW]    = srcQ[k][0].data;
      end else begin
        inValid[k] = 1'b0;
        inLast[k]  = 1'b0;
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, expQ.size(), 0);
    stepCycle();
  endtask

  // Source driver: note which channels handshake mid-cycle, retire them after the edge
  initial begin
    fireMask = '0;
    forever begin
      @(negedge clk);
      fireMask = inValid & inReady;
      @(posedge clk);
      #1;
      for (int k = 0; k < NCH; k++) begin
        if (fireMask[k] && srcQ[k].size() > 0) begin
          void'(srcQ[k].pop_front());
        end
      end
      driveHeads();
    end
  end

  // Monitor: every downstream handshake must match the next expected beat
  initial begin
    forever begin
      @(negedge clk);
      if (outValid === 1'b1 && outReady === 1'b1) begin
        monGot = '{ch: outCh, data: outData, last: outLast};
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL scoreboard_unexpected: actual ch=%0d data=%02h last=%0b, required no beat",
                   outCh, outData, outLast);
        end else begin
          monExp = expQ.pop_front();
          if (monGot !== monExp) begin
            $display("[TB] scoreboard detail: actual ch=%0d data=%02h last=%0b, required ch=%0d data=%02h last=%0b",
                     monGot.ch, monGot.data, monGot.last, monExp.ch, monExp.data, monExp.last);
          end
          checkOutput("scoreboard_beat", 32'(monGot), 32'(monExp));
        end
      end
    end
  end

  // Hard time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    rst       = 1'b1;
    mode      = 1'b1;
    sel       = 2'd0;
    outReady  = 1'b1;
    inValid   = '0;
    inLast    = '0;
    inData    = '0;
    mode3     = 1'b0;
    sel3      = 2'd3;
    in3Valid  = 3'b111;
    in3Last   = 3'b111;
    in3Data   = 24'h33_22_11;
    out3Ready = 1'b1;

    // Reset with every channel holding two single-beat packets
    for (int k = 0; k < NCH; k++) begin
      applyStimulus(2'(k), 8'hC0 + 8'(k), 1'b1);
      applyStimulus(2'(k), 8'hD0 + 8'(k), 1'b1);
    end
    driveHeads();
    for (int k = 0; k < NCH; k++) expectBeat(2'(k), 8'hC0 + 8'(k), 1'b1);
    for (int k = 0; k < NCH; k++) expectBeat(2'(k), 8'hD0 + 8'(k), 1'b1);

    @(negedge clk);
    checkOutput("reset_in_ready", inReady, 4'b0000);
    checkOutput("reset_out_valid", outValid, 1'b0);
    checkOutput("reset_out_data", outData, 8'h00);
    checkOutput("reset_out_ch", outCh, 2'd0);
    @(negedge clk);
    checkOutput("reset_in_ready_hold", inReady, 4'b0000);
    stepCycle();
    rst = 1'b0;

    // Round-robin over all channels, one accept every cycle
    idleCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput("rr_first_grant", inReady, 4'b0001);
      if ((inValid & inReady) == '0) idleCount++;
    end
    checkOutput("rr_no_idle", idleCount, 0);
    waitDrain("rr_drain", 40);

    // Explicit select of ch2, three-beat packet
    mode = 1'b0;
    sel  = 2'd2;
    applyStimulus(2'd2, 8'hA0, 1'b0);
    applyStimulus(2'd2, 8'hA1, 1'b0);
    applyStimulus(2'd2, 8'hA2, 1'b1);
    driveHeads();
    expectBeat(2'd2, 8'hA0, 1'b0);
    expectBeat(2'd2, 8'hA1, 1'b0);
    expectBeat(2'd2, 8'hA2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("explicit_ready", inReady, 4'b0100);
    end
    waitDrain("explicit_drain", 40);

    // Lock: ch1 four-beat packet, ch3 arrives after ch1 owns the output
    mode = 1'b1;
    applyStimulus(2'd1, 8'h10, 1'b0);
    applyStimulus(2'd1, 8'h11, 1'b0);
    applyStimulus(2'd1, 8'h12, 1'b0);
    applyStimulus(2'd1, 8'h13, 1'b1);
    driveHeads();
    expectBeat(2'd1, 8'h10, 1'b0);
    expectBeat(2'd1, 8'h11, 1'b0);
    expectBeat(2'd1, 8'h12, 1'b0);
    expectBeat(2'd1, 8'h13, 1'b1);
    expectBeat(2'd3, 8'h30, 1'b1);
    @(negedge clk);
    checkOutput("lock_first_grant", inReady, 4'b0010);
    stepCycle();
    applyStimulus(2'd3, 8'h30, 1'b1);
    driveHeads();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("lock_ch3_blocked", inReady, 4'b0010);
    end
    @(negedge clk);
    checkOutput("lock_release", inReady, 4'b1000);
    waitDrain("lock_drain", 40);

    // Back-pressure for five cycles mid-packet on ch0
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'd0, 8'h50 + 8'(i), (i == 4));
      expectBeat(2'd0, 8'h50 + 8'(i), (i == 4));
    end
    driveHeads();
    stepCycle();
    stepCycle();
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", outValid, 1'b1);
      checkOutput("bp_out_data", outData, 8'h51);
      checkOutput("bp_out_ch", outCh, 2'd0);
      checkOutput("bp_in_ready", inReady, 4'b0000);
      stepCycle();
    end
    outReady = 1'b1;
    waitDrain("bp_drain", 40);

    // Reset in the middle of a ch2 packet, then restart from ch0
    for (int i = 0; i < 4; i++) applyStimulus(2'd2, 8'h70 + 8'(i), (i == 3));
    driveHeads();
    expectBeat(2'd2, 8'h70, 1'b0);
    expectBeat(2'd2, 8'h71, 1'b0);
    stepCycle();
    stepCycle();
    rst = 1'b1;
    srcQ[2].delete();
    driveHeads();
    @(negedge clk);
    checkOutput("midrst_in_ready", inReady, 4'b0000);
    stepCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", outValid, 1'b0);
    stepCycle();
    applyStimulus(2'd0, 8'h80, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(2'd2, 8'h70 + 8'(i), (i == 3));
    driveHeads();
    expectBeat(2'd0, 8'h80, 1'b1);
    for (int i = 0; i < 4; i++) expectBeat(2'd2, 8'h70 + 8'(i), (i == 3));
    @(negedge clk);
    checkOutput("midrst_rr_restart", inReady, 4'b0001);
    waitDrain("midrst_drain", 40);

    // Three-channel instance: sel=3 is out of range and never grants
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("n3_sel3_ready", in3Ready, 3'b000);
      checkOutput("n3_sel3_out_valid", out3Valid, 1'b0);
    end
    stepCycle();
    sel3 = 2'd1;
    @(negedge clk);
    checkOutput("n3_sel1_ready", in3Ready, 3'b010);

    stepCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
